// File: rtl/debug_cmd_rx_pkg.sv
// Shared debug-channel definitions for the host->CPU command parser.
//   - Command type encodings presented on cmd_type.
//   - ASCII constants for line framing and command letters (lowercase only).
//   - Parser state enumeration.
package debug_cmd_rx_pkg;

   localparam logic [1:0] DBG_CMD_CONT  = 2'd0;
   localparam logic [1:0] DBG_CMD_PAUSE = 2'd1;
   localparam logic [1:0] DBG_CMD_STEP  = 2'd2;
   localparam logic [1:0] DBG_CMD_BREAK = 2'd3;

   localparam logic [7:0] ASCII_LF = 8'h0A;
   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_SP = 8'h20;
   localparam logic [7:0] ASCII_C  = 8'h63;
   localparam logic [7:0] ASCII_P  = 8'h70;
   localparam logic [7:0] ASCII_S  = 8'h73;
   localparam logic [7:0] ASCII_B  = 8'h62;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,   // expecting a command letter
      ST_SEP  = 3'd1,   // after 's'/'b', expecting a single space
      ST_ARG  = 3'd2,   // collecting hex argument digits
      ST_EOL  = 3'd3,   // after 'c'/'p', expecting end of line
      ST_SKIP = 3'd4,   // malformed line, discarding to '\n'
      ST_HOLD = 3'd5    // decoded command presented, waiting for consumer
   } parse_state_e;

endpackage

// File: rtl/debug_hex_nibble.sv
// Combinational ASCII hex-digit decoder.
// Ports:
//   char_in  in  8  ASCII byte
//   is_hex   out 1  byte is '0'-'9', 'a'-'f' or 'A'-'F'
//   nibble   out 4  value of the digit (0 when is_hex=0)
module debug_hex_nibble (
   input  logic [7:0] char_in,
   output logic       is_hex,
   output logic [3:0] nibble
);

   always_comb begin
      is_hex = 1'b0;
      nibble = 4'd0;
      if (char_in >= 8'h30 && char_in <= 8'h39) begin
         is_hex = 1'b1;
         nibble = char_in[3:0];
      end else if ((char_in >= 8'h61 && char_in <= 8'h66) ||
                   (char_in >= 8'h41 && char_in <= 8'h46)) begin
         // 'a'/'A' have low nibble 1, so adding 9 yields 10..15
         is_hex = 1'b1;
         nibble = char_in[3:0] + 4'd9;
      end
   end

endmodule

// File: rtl/debug_cmd_rx.sv
// Host->CPU half of the UART debug channel: parses one text command per
// '\n'-terminated line ("c", "p", "s <hex>", "b <hex>") and presents the
// decoded command with a valid/ready handshake.
// Ports:
//   clk        in   1   system clock
//   rst        in   1   asynchronous active-high reset
//   rdy        in   1   global enable; low freezes all state
//   in_valid   in   1   received byte available
//   in_data    in   8   received ASCII byte
//   in_ready   out  1   byte accepted when in_valid & in_ready
//   cmd_valid  out  1   decoded command held
//   cmd_type   out  2   DBG_CMD_* encoding
//   cmd_arg    out  4*ARG_DIGITS  argument (0 for c/p)
//   cmd_ready  in   1   consumer takes command when cmd_valid & cmd_ready
//   parse_err  out  1   one-cycle pulse when a malformed line is discarded
module debug_cmd_rx
   import debug_cmd_rx_pkg::*;
#(
   parameter int ARG_DIGITS = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    rdy,
   input  logic                    in_valid,
   input  logic [7:0]              in_data,
   output logic                    in_ready,
   output logic                    cmd_valid,
   output logic [1:0]              cmd_type,
   output logic [4*ARG_DIGITS-1:0] cmd_arg,
   input  logic                    cmd_ready,
   output logic                    parse_err
);

   localparam int ARG_W = 4 * ARG_DIGITS;
   localparam int CNT_W = 4;
   localparam logic [CNT_W-1:0] MAX_DIGITS = CNT_W'(ARG_DIGITS);

   parse_state_e     state_q, state_d;
   logic [1:0]       type_q, type_d;
   logic [ARG_W-1:0] arg_q, arg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   logic             accept;
   logic             is_hex;
   logic [3:0]       nibble;

   debug_hex_nibble u_hex (
      .char_in (in_data),
      .is_hex  (is_hex),
      .nibble  (nibble)
   );

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         type_q  <= DBG_CMD_CONT;
         arg_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         type_q  <= type_d;
         arg_q   <= arg_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      type_d  = type_q;
      arg_d   = arg_q;
      cnt_d   = cnt_q;
      // err_d defaults low every cycle so the pulse never stretches, even
      // if rdy drops right after the offending '\n'.
      err_d   = 1'b0;
      accept  = in_valid & in_ready;

      if (rdy) begin
         if (state_q == ST_HOLD) begin
            if (cmd_ready) state_d = ST_IDLE;
         end else if (accept && in_data != ASCII_CR) begin
            unique case (state_q)
               ST_IDLE: begin
                  if (in_data == ASCII_C || in_data == ASCII_P) begin
                     type_d  = (in_data == ASCII_C) ? DBG_CMD_CONT : DBG_CMD_PAUSE;
                     arg_d   = '0;
                     state_d = ST_EOL;
                  end else if (in_data == ASCII_S || in_data == ASCII_B) begin
                     type_d  = (in_data == ASCII_S) ? DBG_CMD_STEP : DBG_CMD_BREAK;
                     arg_d   = '0;
                     cnt_d   = '0;
                     state_d = ST_SEP;
                  end else if (in_data != ASCII_LF) begin
                     state_d = ST_SKIP;
                  end
               end
               ST_SEP: begin
                  if (in_data == ASCII_SP) begin
                     state_d = ST_ARG;
                  end else if (in_data == ASCII_LF) begin
                     err_d   = 1'b1;
                     state_d = ST_IDLE;
                  end else begin
                     state_d = ST_SKIP;
                  end
               end
               ST_ARG: begin
                  if (is_hex) begin
                     if (cnt_q == MAX_DIGITS) begin
                        state_d = ST_SKIP;
                     end else begin
                        arg_d = {arg_q[ARG_W-5:0], nibble};
                        cnt_d = cnt_q + 1'b1;
                     end
                  end else if (in_data == ASCII_LF) begin
                     if (cnt_q != '0) begin
                        state_d = ST_HOLD;
                     end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                     end
                  end else begin
                     state_d = ST_SKIP;
                  end
               end
               ST_EOL: begin
                  state_d = (in_data == ASCII_LF) ? ST_HOLD : ST_SKIP;
               end
               ST_SKIP: begin
                  if (in_data == ASCII_LF) begin
                     err_d   = 1'b1;
                     state_d = ST_IDLE;
                  end
               end
               default: state_d = ST_IDLE;
            endcase
         end
      end
   end

   // Outputs
   always_comb begin
      in_ready  = rdy & (state_q != ST_HOLD);
      cmd_valid = (state_q == ST_HOLD);
      cmd_type  = type_q;
      cmd_arg   = arg_q;
      parse_err = err_q;
   end

endmodule
